dm_lsu: RTL
===========

DM_LSU -- requirements
Module: dm_lsu

Interface
REQ-001 The module SHALL have parameter RD_WAIT, default 1: whole clock cycles from driving dm_read_addr to sampling dm_read_data; legal range 0..7.
REQ-002 The module SHALL have parameter WE_HIGH, default 1: whole clock cycles dm_we is held high per write; legal range 1..7.
REQ-003 The module SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_f, input, 1 bit: reset, synchronous, active-low.
REQ-005 The module SHALL have port req, input, 1 bit: transfer request, sampled only in IDLE.
REQ-006 The module SHALL have port req_we, input, 1 bit: 1 = write burst, 0 = read burst.
REQ-007 The module SHALL have port req_addr, input, 16 bits: first word address.
REQ-008 The module SHALL have port req_len, input, 3 bits: burst length minus one (1..8 words).
REQ-009 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The module SHALL have ports wdata (input, 32 bits), wdata_valid (input, 1 bit) and wdata_ready (output, 1 bit): the write-data handshake.
REQ-011 The module SHALL have ports rdata (output, 32 bits) and rdata_valid (output, 1 bit): read-word delivery, valid for one cycle per word.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle pulse at burst end.
REQ-013 The module SHALL have ports dm_read_addr (output, 16 bits), dm_write_addr (output, 16 bits), dm_write_data (output, 32 bits) and dm_we (output, 1 bit): data-memory drive; the memory commits a write on the falling edge of dm_we.
REQ-014 The module SHALL have port dm_read_data, input, 32 bits: combinational memory read data.

Function
REQ-015 The FSM SHALL have states IDLE, RD_ADDR, RD_WAIT, RD_CAP, WR_DATA, WR_HIGH, WR_LOW and DONE.
REQ-016 In IDLE with req=1, the FSM SHALL latch req_addr into the address counter, latch req_len into the word counter, and go to RD_ADDR (req_we=0) or WR_DATA (req_we=1).
REQ-017 req SHALL be ignored in every state except IDLE.
REQ-018 RD_ADDR SHALL register dm_read_addr from the address counter for one cycle, then go to RD_WAIT; with RD_WAIT=0 it SHALL go directly to RD_CAP.
REQ-019 RD_WAIT SHALL last exactly RD_WAIT cycles, with dm_read_addr held stable.
REQ-020 RD_CAP SHALL register dm_read_data into rdata and assert rdata_valid for the following single cycle.
REQ-021 Each read word SHALL take RD_WAIT+2 cycles.
REQ-022 rdata SHALL hold its last value when rdata_valid is low.
REQ-023 In WR_DATA, wdata_ready SHALL be 1 (it is 0 in all other states).
REQ-024 On a WR_DATA cycle with wdata_valid=1, the module SHALL register wdata into dm_write_data and the address counter into dm_write_addr, then go to WR_HIGH.
REQ-025 When wdata_valid=0 in WR_DATA, the FSM SHALL wait indefinitely.
REQ-026 In WR_HIGH, dm_we SHALL be 1 for exactly WE_HIGH cycles, then WR_LOW.
REQ-027 In WR_LOW, dm_we SHALL be 0, with dm_write_addr and dm_write_data held unchanged for that cycle (hold after the commit edge).
REQ-028 dm_write_addr and dm_write_data SHALL change only on a WR_DATA handshake.
REQ-029 After RD_CAP or WR_LOW, if the word counter is nonzero, the module SHALL decrement it, increment the address counter modulo 2^16 (0xFFFF -> 0x0000), and return to RD_ADDR or WR_DATA; otherwise it SHALL go to DONE.
REQ-030 DONE SHALL assert done for one cycle, then go to IDLE; busy SHALL be low on the cycle after done.
REQ-031 dm_we SHALL be a registered output, glitch-free, high only in WR_HIGH.

Reset
REQ-032 When rst_f=0 at a rising clk edge, the FSM SHALL go to IDLE, and the outputs SHALL take the values: busy=0, done=0, rdata_valid=0, wdata_ready=0, dm_we=0, rdata=0, dm_read_addr=0, dm_write_addr=0, dm_write_data=0, with both counters cleared.
REQ-033 Reset SHALL take priority over all other inputs.
REQ-034 Reset asserted during WR_HIGH SHALL drop dm_we to 0 while keeping dm_write_addr and dm_write_data unchanged on that edge (they clear on the next reset edge), so the in-flight word commits intact.
REQ-035 Reset asserted during a read SHALL discard the pending word with no rdata_valid.

Verification
REQ-036 Reset then idle: hold rst_f=0 for 2 cycles, release -> every output 0, busy=0, and no dm_we edge.
REQ-037 Single read: preload mem[0x0010]=0xDEADBEEF; req, req_we=0, addr=0x0010, len=0 -> rdata_valid=1 with rdata=0xDEADBEEF on cycle 3 after the req edge, then done pulse, then busy=0.
REQ-038 Burst write with stall: addr=0x0020, len=3, wdata_valid low for 2 cycles before word 1 -> mem[0x20..0x23] equal the 4 supplied words; dm_we high exactly 4 times, each for WE_HIGH cycles; dm_write_addr stable across every dm_we fall.
REQ-039 Address wrap: read burst addr=0xFFFE, len=3 -> dm_read_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, with 4 rdata_valid pulses.
REQ-040 Reset mid-write: assert rst_f=0 while dm_we=1 for word 0 of addr=0x0030 -> mem[0x0030] holds the written word, the FSM is in IDLE, and no further dm_we pulses occur.
REQ-041 req during busy: pulse req during a read burst -> no second burst starts, and exactly one done pulse occurs.

Source files
------------

// File: rtl/dm_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : dm_lsu
//  Description : Burst load/store unit driving a simple data memory. Reads
//                wait a fixed number of cycles before capturing combinational
//                read data; writes hold a registered write-enable for a fixed
//                number of cycles with address/data held past its falling
//                (commit) edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_lsu #(
   parameter int RD_WAIT = 1,
   parameter int WE_HIGH = 1
) (
   input  logic        clk,
   input  logic        rst_f,
   input  logic        req,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [2:0]  req_len,
   output logic        busy,
   input  logic [31:0] wdata,
   input  logic        wdata_valid,
   output logic        wdata_ready,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        done,
   output logic [15:0] dm_read_addr,
   output logic [15:0] dm_write_addr,
   output logic [31:0] dm_write_data,
   output logic        dm_we,
   input  logic [31:0] dm_read_data
);

   // Wait counters count down to zero, so they are loaded with length-1.
   localparam logic [2:0] RD_WAIT_LOAD = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;
   localparam logic [2:0] WE_HIGH_LOAD = (WE_HIGH > 0) ? 3'(WE_HIGH - 1) : 3'd0;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_RD_CAP  = 3'd3,
      ST_WR_DATA = 3'd4,
      ST_WR_HIGH = 3'd5,
      ST_WR_LOW  = 3'd6,
      ST_DONE    = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [2:0]  len_q, len_d;
   logic [2:0]  wait_q, wait_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rdata_valid_q, rdata_valid_d;
   logic [15:0] rd_addr_q, rd_addr_d;
   logic [15:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        dm_we_q, dm_we_d;

   // Next-state and datapath computation for the burst sequencer.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      len_d         = len_q;
      wait_d        = wait_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      rd_addr_d     = rd_addr_q;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d  = req_addr;
               len_d   = req_len;
               state_d = req_we ? ST_WR_DATA : ST_RD_ADDR;
            end
         end
         ST_RD_ADDR: begin
            rd_addr_d = addr_q;
            if (RD_WAIT == 0) begin
               state_d = ST_RD_CAP;
            end else begin
               wait_d  = RD_WAIT_LOAD;
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (wait_q == 3'd0) state_d = ST_RD_CAP;
            else                wait_d  = wait_q - 3'd1;
         end
         ST_RD_CAP, ST_WR_LOW: begin
            if (state_q == ST_RD_CAP) begin
               rdata_d       = dm_read_data;
               rdata_valid_d = 1'b1;
            end
            // Word finished: either step to the next word or end the burst.
            if (len_q != 3'd0) begin
               len_d   = len_q - 3'd1;
               addr_d  = addr_q + 16'd1;
               state_d = (state_q == ST_RD_CAP) ? ST_RD_ADDR : ST_WR_DATA;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_WR_DATA: begin
            if (wdata_valid) begin
               wr_data_d = wdata;
               wr_addr_d = addr_q;
               wait_d    = WE_HIGH_LOAD;
               state_d   = ST_WR_HIGH;
            end
         end
         ST_WR_HIGH: begin
            if (wait_q == 3'd0) state_d = ST_WR_LOW;
            else                wait_d  = wait_q - 3'd1;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Registering the decode of the next state keeps dm_we glitch-free.
      dm_we_d = (state_d == ST_WR_HIGH);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         state_q       <= ST_IDLE;
         addr_q        <= 16'd0;
         len_q         <= 3'd0;
         wait_q        <= 3'd0;
         rdata_q       <= 32'd0;
         rdata_valid_q <= 1'b0;
         rd_addr_q     <= 16'd0;
         dm_we_q       <= 1'b0;
         // A reset landing mid-pulse drops dm_we but keeps address/data for
         // this edge so the memory commits the in-flight word intact.
         if (state_q != ST_WR_HIGH) begin
            wr_addr_q <= 16'd0;
            wr_data_q <= 32'd0;
         end
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         len_q         <= len_d;
         wait_q        <= wait_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         rd_addr_q     <= rd_addr_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         dm_we_q       <= dm_we_d;
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_DONE);
   assign wdata_ready   = (state_q == ST_WR_DATA);
   assign rdata         = rdata_q;
   assign rdata_valid   = rdata_valid_q;
   assign dm_read_addr  = rd_addr_q;
   assign dm_write_addr = wr_addr_q;
   assign dm_write_data = wr_data_q;
   assign dm_we         = dm_we_q;

endmodule
`default_nettype wire
